axi4_slave_mem: RTL

AXI4-subset memory-backed responder, the target side of the team's axi4_master. It accepts one incrementing write burst (AW/W/B) and one incrementing read burst (AR/R) at a time. The write and read channels are independent of each other. Storage is an internal word array. It is used as the default slave in master-level simulations and as a synthesizable scratch RAM.

---
 rtl/axi4_pkg.sv | 23 ++
 rtl/axi_mem_array.sv | 43 ++++
 rtl/axi4_slave_mem.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/axi4_pkg.sv
// Shared definitions for the AXI4-subset memory responder: FSM encodings,
// burst length width and the memory index width helper.
package axi4_pkg;

    localparam int AXI_LEN_W = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_e;

    // A single-word memory still needs a one-bit index.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// DEPTH x DATA_W word array: one synchronous write port, one registered read
// port. A read and a write to the same word on one edge returns the old word.
module axi_mem_array
    import axi4_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int INIT_ZERO = 1,
    parameter int IDX_W     = idx_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam logic [DATA_W-1:0] INIT_WORD = (INIT_ZERO != 0) ? {DATA_W{1'b0}} : {DATA_W{1'bx}};

    // Power-up contents only; reset deliberately leaves the array alone.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: INIT_WORD};
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4-subset memory responder: one INCR write burst and one INCR read burst
// in flight at a time, on independent channels, backed by axi_mem_array.
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 256,
    parameter int INIT_ZERO = 1
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [ADDR_W-1:0]    AWADDR,
    input  logic [AXI_LEN_W-1:0] AWLEN,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [DATA_W-1:0]    WDATA,
    input  logic                 WLAST,
    input  logic                 WVALID,
    output logic                 WREADY,
    output logic                 BVALID,
    input  logic                 BREADY,
    input  logic [ADDR_W-1:0]    ARADDR,
    input  logic [AXI_LEN_W-1:0] ARLEN,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [DATA_W-1:0]    RDATA,
    output logic                 RLAST,
    output logic                 RVALID,
    input  logic                 RREADY,
    output logic                 wlast_err
);

    localparam int IDX_W = idx_width(DEPTH);

    logic [IDX_W-1:0] aw_idx, ar_idx;
    logic             unused_addr_bits;

    // Upper address bits are ignored so accesses alias modulo DEPTH.
    assign aw_idx = AWADDR[IDX_W+1:2];
    assign ar_idx = ARADDR[IDX_W+1:2];
    assign unused_addr_bits = ^{AWADDR[ADDR_W-1:IDX_W+2], AWADDR[1:0],
                                ARADDR[ADDR_W-1:IDX_W+2], ARADDR[1:0]};

    // ---------------- write channel ----------------
    w_state_e             w_state_q;
    logic [IDX_W-1:0]     w_idx_q;
    logic [AXI_LEN_W-1:0] w_len_q, w_cnt_q;
    logic                 awready_q, wready_q, bvalid_q, wlast_err_q;
    logic                 w_beat, w_final;

    assign w_beat  = (w_state_q == W_DATA) && WVALID && wready_q;
    assign w_final = (w_cnt_q == w_len_q);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q   <= W_IDLE;
            w_idx_q     <= '0;
            w_len_q     <= '0;
            w_cnt_q     <= '0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (!awready_q) begin
                        awready_q <= 1'b1;
                    end else if (AWVALID) begin
                        w_idx_q   <= aw_idx;
                        w_len_q   <= AWLEN;
                        w_cnt_q   <= '0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_beat) begin
                        w_idx_q <= w_idx_q + IDX_W'(1);
                        w_cnt_q <= w_cnt_q + 8'd1;
                        // Beat count alone ends the burst; WLAST is only audited.
                        if (WLAST != w_final) begin
                            wlast_err_q <= 1'b1;
                        end
                        if (w_final) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            w_state_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // ---------------- read channel ----------------
    r_state_e             r_state_q;
    logic [IDX_W-1:0]     r_idx_q;
    logic [AXI_LEN_W-1:0] r_len_q, r_cnt_q;
    logic                 arready_q, rvalid_q, rlast_q;
    logic                 ar_hs, r_adv;
    logic                 mem_re;
    logic [IDX_W-1:0]     mem_raddr;

    assign ar_hs = (r_state_q == R_IDLE) && ARVALID && arready_q;
    assign r_adv = (r_state_q == R_DATA) && rvalid_q && RREADY && !rlast_q;

    // The read register only loads on AR accept or an accepted non-last beat,
    // which keeps RDATA stable across stalls.
    always_comb begin
        mem_re    = ar_hs || r_adv;
        mem_raddr = ar_hs ? ar_idx : r_idx_q;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (!arready_q) begin
                        arready_q <= 1'b1;
                    end else if (ARVALID) begin
                        r_idx_q   <= ar_idx + IDX_W'(1);
                        r_len_q   <= ARLEN;
                        r_cnt_q   <= '0;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rlast_q   <= (ARLEN == 8'd0);
                        r_state_q <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (rvalid_q && RREADY) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            r_idx_q <= r_idx_q + IDX_W'(1);
                            r_cnt_q <= r_cnt_q + 8'd1;
                            rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
                        end
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    axi_mem_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_ZERO (INIT_ZERO),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk_i   (ACLK),
        .rst_ni  (ARESETn),
        .we_i    (w_beat),
        .waddr_i (w_idx_q),
        .wdata_i (WDATA),
        .re_i    (mem_re),
        .raddr_i (mem_raddr),
        .rdata_o (RDATA)
    );

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign ARREADY   = arready_q;
    assign RVALID    = rvalid_q;
    assign RLAST     = rlast_q;
    assign wlast_err = wlast_err_q;

endmodule
